// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM encoding and default width for the sequential execute-stage ALU.
package seq_alu_pkg;
    localparam int WIDTH_DEF = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;
endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: shift-add unsigned multiply and restoring unsigned divide, one bit per cycle.
module seq_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_mul,
    input  logic               start_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem
);
    localparam int CW = $clog2(WIDTH + 1);

    logic               busy_q, busy_d;
    logic               mode_div_q, mode_div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   opb_q, opb_d;

    logic [2*WIDTH-1:0] mul_acc, div_acc;
    logic [WIDTH:0]     trial, diff;

    // acc holds the running product for MULTU, and {remainder, dividend/quotient} for DIVU
    always_comb begin
        mul_acc = acc_q + (opb_q[0] ? mcand_q : '0);
        trial   = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = trial - {1'b0, opb_q};
        if (trial >= {1'b0, opb_q})
            div_acc = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            div_acc = {acc_q[2*WIDTH-2:0], 1'b0};
    end

    assign done = busy_q && (cnt_q == CW'(1));
    assign prod = mul_acc;
    assign quot = div_acc[WIDTH-1:0];
    assign rem  = div_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        busy_d     = busy_q;
        mode_div_d = mode_div_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        opb_d      = opb_q;
        if (start_mul) begin
            busy_d     = 1'b1;
            mode_div_d = 1'b0;
            cnt_d      = CW'(WIDTH);
            acc_d      = '0;
            mcand_d    = {{WIDTH{1'b0}}, a};
            opb_d      = b;
        end else if (start_div) begin
            busy_d     = 1'b1;
            mode_div_d = 1'b1;
            cnt_d      = CW'(WIDTH);
            acc_d      = {{WIDTH{1'b0}}, a};
            opb_d      = b;
        end else if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                busy_d = 1'b0;
            if (mode_div_q) begin
                acc_d = div_acc;
            end else begin
                acc_d   = mul_acc;
                mcand_d = mcand_q << 1;
                opb_d   = opb_q >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            mode_div_q <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            opb_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            mode_div_q <= mode_div_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            opb_q      <= opb_d;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops plus iterative MULTU/DIVU with HI/LO.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_e state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept, start_mul, start_div, it_done;
    logic [2*WIDTH-1:0] it_prod;
    logic [WIDTH-1:0] it_quot, it_rem;

    logic [WIDTH-1:0] sum, dif, alu_res;
    logic             ovf_add, ovf_sub, slt, alu_ovf, alu_legal;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_mul (start_mul),
        .start_div (start_div),
        .a         (a),
        .b         (b),
        .done      (it_done),
        .prod      (it_prod),
        .quot      (it_quot),
        .rem       (it_rem)
    );

    // SLT takes sign xor overflow so it stays correct when a-b wraps
    always_comb begin
        sum       = a + b;
        dif       = a - b;
        ovf_add   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        ovf_sub   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
        slt       = dif[WIDTH-1] ^ ovf_sub;
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_legal = 1'b1;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  begin alu_res = sum; alu_ovf = ovf_add; end
            OP_SUB:  begin alu_res = dif; alu_ovf = ovf_sub; end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(b) >>> shamt);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        start_mul   = 1'b0;
        start_div   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_MULTU) begin
                        start_mul = 1'b1;
                        state_d   = ST_MUL;
                    end else if (op == OP_DIVU && b != '0) begin
                        start_div = 1'b1;
                        state_d   = ST_DIV;
                    end else if (op == OP_DIVU) begin
                        out_valid_d = 1'b1;
                        result_d    = '1;
                        zero_d      = 1'b0;
                        ovf_d       = 1'b0;
                        dbz_d       = 1'b1;
                        hi_d        = a;
                        lo_d        = '1;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        zero_d      = alu_legal && (alu_res == '0);
                        ovf_d       = alu_ovf;
                        dbz_d       = 1'b0;
                    end
                end
            end
            ST_MUL: begin
                if (it_done) begin
                    out_valid_d = 1'b1;
                    {hi_d, lo_d} = it_prod;
                    result_d    = it_prod[WIDTH-1:0];
                    zero_d      = (it_prod[WIDTH-1:0] == '0);
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (it_done) begin
                    out_valid_d = 1'b1;
                    hi_d        = it_rem;
                    lo_d        = it_quot;
                    result_d    = it_quot;
                    zero_d      = (it_quot == '0);
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at accept, compared on each out_valid pulse.
module tb_seq_alu;
    localparam int W = 32;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic [4:0]   shamt = '0;
    logic         in_ready, out_valid, zero, overflow, div_by_zero;
    logic [W-1:0] result, hi, lo;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
        .result(result), .zero(zero), .overflow(overflow),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        tag;
        logic [W-1:0] res, hi, lo;
        logic         z, ov, dz;
        int           lat, acc;
    } exp_t;

    exp_t sb[$];
    logic [W-1:0] m_hi = '0, m_lo = '0;
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [4:0] s);
        exp_t e;
        longint sx, sy, t;
        logic [63:0] p;
        logic legal;
        sx = $signed(x); sy = $signed(y);
        e.res = '0; e.ov = 1'b0; e.dz = 1'b0; e.lat = 0; e.acc = 0; e.tag = "";
        legal = 1'b1;
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: begin t = sx + sy; e.res = t[31:0]; e.ov = (t > MAXS) || (t < MINS); end
            4'd6: begin t = sx - sy; e.res = t[31:0]; e.ov = (t > MAXS) || (t < MINS); end
            4'd7: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'd3: e.res = y << s;
            4'd4: e.res = y >> s;
            4'd5: e.res = $signed(y) >>> s;
            4'd8: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32]; m_lo = p[31:0]; e.res = m_lo; e.lat = W;
            end
            4'd9: begin
                if (y == 0) begin
                    m_hi = x; m_lo = '1; e.res = '1; e.dz = 1'b1;
                end else begin
                    m_lo = x / y; m_hi = x % y; e.res = m_lo; e.lat = W;
                end
            end
            4'd10: e.res = m_hi;
            4'd11: e.res = m_lo;
            default: legal = 1'b0;
        endcase
        e.z  = legal && (e.res == 0);
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [4:0] s);
        exp_t e;
        int g;
        op = o; a = x; b = y; shamt = s; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
        if (!in_ready) chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
        e = model(o, x, y, s);
        e.tag = tag;
        @(posedge clk); #1;
        e.acc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin @(posedge clk); g++; end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, ".result"}, result, e.res);
                chk({e.tag, ".zero"}, zero, e.z);
                chk({e.tag, ".overflow"}, overflow, e.ov);
                chk({e.tag, ".div_by_zero"}, div_by_zero, e.dz);
                chk({e.tag, ".hi"}, hi, e.hi);
                chk({e.tag, ".lo"}, lo, e.lo);
                chk({e.tag, ".latency"}, cyc - e.acc, e.lat);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.zero", zero, 0);
        chk("rst.overflow", overflow, 0);
        chk("rst.div_by_zero", div_by_zero, 0);
        chk("rst.hi", hi, 0);
        chk("rst.lo", lo, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.in_ready", in_ready, 1);

        issue("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
        issue("slt_ovf", 4'b0111, 32'h7FFFFFFF, 32'h1, 5'd0);
        issue("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0);
        issue("sra", 4'b0101, 32'h0, 32'h80000000, 5'd4);
        issue("srl", 4'b0100, 32'h0, 32'h80000000, 5'd4);
        issue("sll", 4'b0011, 32'h0, 32'h0000_00F1, 5'd31);
        issue("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        issue("or", 4'b0001, 32'hF000_0000, 32'h0000_000F, 5'd0);
        issue("sub_ovf", 4'b0110, 32'h80000000, 32'h1, 5'd0);
        issue("slt_neg", 4'b0111, 32'h80000000, 32'h1, 5'd0);
        issue("illegal", 4'b1111, 32'h1, 32'h2, 5'd3);
        drain();

        issue("multu_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        chk("multu.busy", in_ready, 0);
        issue("mfhi", 4'b1010, 32'h0, 32'h0, 5'd0);
        issue("mflo", 4'b1011, 32'h0, 32'h0, 5'd0);
        issue("divu", 4'b1001, 32'd100, 32'd7, 5'd0);
        issue("divu_zero", 4'b1001, 32'd9, 32'd0, 5'd0);
        drain();

        issue("multu_rst", 4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        m_hi = '0; m_lo = '0;
        #1;
        chk("abort.out_valid", out_valid, 0);
        chk("abort.hi", hi, 0);
        chk("abort.lo", lo, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort.in_ready", in_ready, 1);
        repeat (40) @(posedge clk);
        #1;
        issue("add_post_rst", 4'b0010, 32'd2, 32'd3, 5'd0);
        drain();

        issue("divu_hold", 4'b1001, 32'd1000, 32'd3, 5'd0);
        issue("add_held", 4'b0010, 32'd10, 32'd20, 5'd0);
        drain();

        for (int i = 0; i < 24; i++) begin
            logic [3:0] o;
            o = 4'($urandom_range(0, 15));
            issue($sformatf("rnd%0d_op%0d", i, o), o, $urandom, $urandom, 5'($urandom_range(0, 31)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked execute-stage ALU for the pipelined CPU; successor to the fixed 32-bit single-cycle ALU.
- Keeps the legacy single-cycle operation set and adds SRL, SRA and signed-overflow detection.
- Adds iterative unsigned multiply and divide, with architectural HI/LO registers and MFHI/MFLO reads.
- EX-stage control stalls the pipeline while in_ready is low.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  reset; asynchronous assert, synchronous deassert, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept a request this cycle.
- op  in  4  operation code; see Behaviour.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or immediate).
- shamt  in  SHW  shift amount.
- out_valid  out  1  one-cycle pulse; result and flags are valid.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow; ADD and SUB only.
- div_by_zero  out  1  DIVU issued with b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 SLL, 0100 SRL, 0101 SRA, 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO. Any other code gives result 0, out_valid still pulses and flags are 0.
- Shifts act on b by shamt. SLT uses the true signed comparison (sign XOR overflow), so it is correct even when a−b overflows.
- A request is accepted when in_valid && in_ready. in_ready = (state == IDLE).
- There is no output backpressure; out_valid is a single-cycle pulse.

State machine, states IDLE, MUL, DIV:
- IDLE, accepted single-cycle op: result and flags are registered. out_valid = 1 in the next cycle. Stays in IDLE, so back-to-back ops run at one per cycle.
- IDLE, accepted MULTU: latch a and b. Clear the accumulator. Count = WIDTH. Go to MUL.
- IDLE, accepted DIVU: latch operands. Clear the remainder. Count = WIDTH. Go to DIV.
- IDLE, accepted DIVU with b == 0: no iteration. Next cycle: out_valid = 1, div_by_zero = 1, lo = all-ones, hi = a, result = all-ones. Stays in IDLE.
- MUL: shift-add one bit per cycle and decrement count. At count == 1: write the 2·WIDTH product to {hi, lo}, set result = low half, go to IDLE. out_valid is high in the following cycle.
- DIV: restoring division, one quotient bit per cycle. On completion lo = quotient, hi = remainder, result = quotient, go to IDLE.
- Latency: single-cycle ops 1 cycle; MULTU and DIVU WIDTH + 1 cycles from the accept edge to out_valid.
- hi and lo change only when MULTU or DIVU completes.
- MFHI and MFLO issued on the cycle a MULTU or DIVU completes see the new values; in_ready gating guarantees ordering.
- zero, overflow and div_by_zero are registered alongside result and are valid only with out_valid. overflow and div_by_zero are 0 for every other op.
- Reset values: in_ready 1 (after release), out_valid 0, result 0, zero 0, overflow 0, div_by_zero 0, hi 0, lo 0, state IDLE.
- rst_n asserted mid-MUL or mid-DIV aborts immediately. hi and lo return to 0 and no out_valid is produced.
- in_valid during MUL or DIV is ignored; the request is not accepted.
- Multiply wrap-around: the full product never truncates, because {hi, lo} holds all 2·WIDTH bits.

Decomposition:
- Shared package seq_alu_pkg holds:
  - op-code localparams (OP_AND ... OP_MFLO);
  - state encoding (ST_IDLE, ST_MUL, ST_DIV);
  - the WIDTH default.
- Sub-module seq_alu_iter contains the shared MUL/DIV datapath: operand/accumulator registers, iteration counter, done strobe.
- The top level contains the single-cycle combinational ops, the output registers and the handshake.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1 → next cycle out_valid=1, result=0x80000000, overflow=1, zero=0. Then SLT with the same operands → result=0 (correct despite overflow).
- SUB a=5, b=5 → result=0, zero=1. SRA b=0x80000000, shamt=4 → result=0xF8000000. SRL with the same operands → 0x08000000.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → in_ready low for 32 cycles, out_valid at accept+33, hi=0xFFFFFFFE, lo=0x00000001. Follow with MFHI → result=0xFFFFFFFE.
- DIVU a=100, b=7 → lo=14, hi=2, result=14 after 33 cycles. DIVU a=9, b=0 → next cycle div_by_zero=1, lo=0xFFFFFFFF, hi=9.
- Assert rst_n low 10 cycles into a MULTU → out_valid never pulses, hi=lo=0, in_ready=1 after release. A fresh ADD 2+3 → result 5.
- Hold in_valid high with ADD during a DIVU → no accept until in_ready returns. Exactly one out_valid per accepted op; the ADD result follows the DIVU result by one cycle.
